stream_dest_router: RTL and testbench

//  Routes one AXI-Stream-style input to one of M_DATA_COUNT outputs chosen by TDEST.

---
 rtl/stream_dest_router.sv | 183 ++++++++++++++++++
 tb/tb_stream_dest_router.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_dest_router.sv
// stream_dest_router: steers one AXI-Stream-style input onto one of M_DATA_COUNT
// outputs selected by TDEST. The route is captured on the first beat of a packet
// and held until TLAST. A single output register holds one beat in flight and
// reloads on the same edge it is popped, so a ready lane sees full throughput.
// Optional feature macro: STREAM_ROUTER_DROP_BAD_DEST_EN
//   defined   - packets whose first-beat dest is out of range are discarded and
//               counted in err_cnt_o (saturating at 255).
//   undefined - out-of-range dest clamps to the highest lane; err_cnt_o is 0.
module stream_dest_router #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 5,
  parameter int M_DATA_COUNT = 3,
  parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [T_DATA_WIDTH-1:0]            s_data_i,
  input  logic                               s_valid_i,
  output logic                               s_ready_o,
  input  logic                               s_last_i,
  input  logic [T_ID___WIDTH-1:0]            s_id_i,
  input  logic [T_DEST_WIDTH-1:0]            s_dest_i,
  output logic [M_DATA_COUNT*T_DATA_WIDTH-1:0] m_data_o,
  output logic [M_DATA_COUNT-1:0]            m_valid_o,
  input  logic [M_DATA_COUNT-1:0]            m_ready_i,
  output logic [M_DATA_COUNT-1:0]            m_last_o,
  output logic [M_DATA_COUNT*T_ID___WIDTH-1:0] m_id_o,
  output logic [7:0]                         err_cnt_o
);

  // One bit wider than the dest field so the lane count itself is representable.
  localparam logic [T_DEST_WIDTH:0]   DEST_LIMIT = (T_DEST_WIDTH+1)'(M_DATA_COUNT);
  localparam logic [T_DEST_WIDTH-1:0] DEST_MAX   = T_DEST_WIDTH'(M_DATA_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                  state_r;
  logic [T_DEST_WIDTH-1:0] route_r;
  logic                    out_valid_r;
  logic [T_DATA_WIDTH-1:0] out_data_r;
  logic                    out_last_r;
  logic [T_ID___WIDTH-1:0] out_id_r;
  logic [T_DEST_WIDTH-1:0] out_dest_r;
`ifdef STREAM_ROUTER_DROP_BAD_DEST_EN
  logic [7:0]              err_cnt_r;
`endif

  logic                    dest_ok_s;
  logic [T_DEST_WIDTH-1:0] first_dest_s;
  logic [T_DEST_WIDTH-1:0] beat_dest_s;
  logic                    pop_s;
  logic                    ready_s;
  logic                    accept_s;
  logic                    drop_s;
  logic                    load_s;

  // Handshake decode: route selection for the current beat, pop/accept/drop qualifiers.
  always_comb begin
    dest_ok_s = ({1'b0, s_dest_i} < DEST_LIMIT);
    if (dest_ok_s) begin
      first_dest_s = s_dest_i;
    end else begin
      first_dest_s = DEST_MAX;
    end
    if (state_r == ST_IDLE) begin
      beat_dest_s = first_dest_s;
    end else begin
      beat_dest_s = route_r;
    end
    // Only the lane currently holding the beat can stall the input.
    pop_s = out_valid_r && m_ready_i[out_dest_r];
`ifdef STREAM_ROUTER_DROP_BAD_DEST_EN
    if (state_r == ST_DROP) begin
      ready_s = 1'b1;
    end else begin
      ready_s = !out_valid_r || pop_s;
    end
    accept_s = s_valid_i && ready_s;
    if (state_r == ST_DROP) begin
      drop_s = accept_s;
    end else if (state_r == ST_IDLE) begin
      drop_s = accept_s && !dest_ok_s;
    end else begin
      drop_s = 1'b0;
    end
`else
    ready_s  = !out_valid_r || pop_s;
    accept_s = s_valid_i && ready_s;
    drop_s   = 1'b0;
`endif
    load_s = accept_s && !drop_s;
  end

  // Packet framing FSM: latches the route on the first beat, releases it on TLAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      route_r <= '0;
`ifdef STREAM_ROUTER_DROP_BAD_DEST_EN
      err_cnt_r <= 8'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
`ifdef STREAM_ROUTER_DROP_BAD_DEST_EN
            if (drop_s) begin
              if (err_cnt_r != 8'd255) begin
                err_cnt_r <= err_cnt_r + 8'd1;
              end
              state_r <= s_last_i ? ST_IDLE : ST_DROP;
            end else begin
              route_r <= first_dest_s;
              state_r <= s_last_i ? ST_IDLE : ST_PKT;
            end
`else
            route_r <= first_dest_s;
            state_r <= s_last_i ? ST_IDLE : ST_PKT;
`endif
          end
        end
        ST_PKT: begin
          if (accept_s && s_last_i) begin
            state_r <= ST_IDLE;
          end
        end
        ST_DROP: begin
`ifdef STREAM_ROUTER_DROP_BAD_DEST_EN
          if (accept_s && s_last_i) begin
            state_r <= ST_IDLE;
          end
`else
          state_r <= ST_IDLE;
`endif
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Output register: load on accept, clear on pop without reload, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      out_id_r    <= '0;
      out_dest_r  <= '0;
    end else if (load_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= s_data_i;
      out_last_r  <= s_last_i;
      out_id_r    <= s_id_i;
      out_dest_r  <= beat_dest_s;
    end else if (pop_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Lane valid decode from the registered destination.
  always_comb begin
    m_valid_o = '0;
    for (int k = 0; k < M_DATA_COUNT; k++) begin
      m_valid_o[k] = out_valid_r && (out_dest_r == T_DEST_WIDTH'(k));
    end
  end

  assign s_ready_o = ready_s;
  assign m_data_o  = {M_DATA_COUNT{out_data_r}};
  assign m_last_o  = {M_DATA_COUNT{out_last_r}};
  assign m_id_o    = {M_DATA_COUNT{out_id_r}};
`ifdef STREAM_ROUTER_DROP_BAD_DEST_EN
  assign err_cnt_o = err_cnt_r;
`else
  assign err_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_stream_dest_router.sv
// Directed testbench for stream_dest_router with a short randomized scoreboard run.
module tb_stream_dest_router;

  localparam int DW = 8;
  localparam int IW = 3;
  localparam int DESTW = 2;
  localparam int M = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DW-1:0]     s_data_i;
  logic              s_valid_i;
  logic              s_ready_o;
  logic              s_last_i;
  logic [IW-1:0]     s_id_i;
  logic [DESTW-1:0]  s_dest_i;
  logic [M*DW-1:0]   m_data_o;
  logic [M-1:0]      m_valid_o;
  logic [M-1:0]      m_ready_i;
  logic [M-1:0]      m_last_o;
  logic [M*IW-1:0]   m_id_o;
  logic [7:0]        err_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q [M][$];
  logic [11:0] ent;
  int          pkt_left;
  int          first;
  int          pkt_bad;
  int          accepted;
  int          beats;
  int          cycles;
  logic [1:0]  pkt_dest;

  stream_dest_router dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_last_i  (s_last_i),
    .s_id_i    (s_id_i),
    .s_dest_i  (s_dest_i),
    .m_data_o  (m_data_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_last_o  (m_last_o),
    .m_id_o    (m_id_o),
    .err_cnt_o (err_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lane_data(input int k);
    return m_data_o[k*DW +: DW];
  endfunction

  function automatic logic [2:0] lane_id(input int k);
    return m_id_o[k*IW +: IW];
  endfunction

  function automatic int lane_of(input logic [1:0] d);
    return (d >= 2'd3) ? 2 : int'(d);
  endfunction

  task automatic send_beat(input logic [7:0] d, input logic [1:0] dest, input logic last,
                           input logic [2:0] id);
    s_data_i  = d;
    s_dest_i  = dest;
    s_last_i  = last;
    s_id_i    = id;
    s_valid_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    s_valid_i = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    s_data_i  = 8'h00;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    s_id_i    = 3'd0;
    s_dest_i  = 2'd0;
    m_ready_i = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(s_ready_o), 32'd1);
    chk("rst_valid", 32'(m_valid_o), 32'd0);

    // 1: reset in the middle of a packet
    send_beat(8'h5A, 2'd1, 1'b0, 3'd2);
    chk("pre_rst_valid", 32'(m_valid_o), 32'b010);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(m_valid_o), 32'd0);
    chk("midrst_err", 32'(err_cnt_o), 32'd0);
    chk("midrst_data", 32'(m_data_o), 32'd0);
    chk("midrst_last", 32'(m_last_o), 32'd0);
    s_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(s_ready_o), 32'd1);

    // 2: three-beat packet to lane 2; later dest changes ignored
    send_beat(8'h11, 2'd2, 1'b0, 3'd1);
    chk("p2_b1_valid", 32'(m_valid_o), 32'b100);
    chk("p2_b1_data", 32'(lane_data(2)), 32'h11);
    chk("p2_b1_last", 32'(m_last_o[2]), 32'd0);
    send_beat(8'h22, 2'd0, 1'b0, 3'd1);
    chk("p2_b2_valid", 32'(m_valid_o), 32'b100);
    chk("p2_b2_data", 32'(lane_data(2)), 32'h22);
    send_beat(8'h33, 2'd0, 1'b1, 3'd1);
    chk("p2_b3_valid", 32'(m_valid_o), 32'b100);
    chk("p2_b3_data", 32'(lane_data(2)), 32'h33);
    chk("p2_b3_last", 32'(m_last_o[2]), 32'd1);
    chk("p2_b3_id", 32'(lane_id(2)), 32'd1);
    idle_cycle();
    chk("p2_drain", 32'(m_valid_o), 32'd0);

    // 3: back-to-back single-beat packets, lane 1 then lane 0
    send_beat(8'h44, 2'd1, 1'b1, 3'd3);
    chk("p3_a_valid", 32'(m_valid_o), 32'b010);
    chk("p3_a_data", 32'(lane_data(1)), 32'h44);
    chk("p3_a_last", 32'(m_last_o[1]), 32'd1);
    s_data_i = 8'h55;
    s_dest_i = 2'd0;
    s_last_i = 1'b1;
    s_id_i   = 3'd4;
    #1;
    chk("p3_no_bubble", 32'(s_ready_o), 32'd1);
    @(posedge clk);
    #1;
    chk("p3_b_valid", 32'(m_valid_o), 32'b001);
    chk("p3_b_data", 32'(lane_data(0)), 32'h55);
    chk("p3_b_id", 32'(lane_id(0)), 32'd4);
    idle_cycle();

    // 4: backpressure on lane 1 only
    send_beat(8'h61, 2'd1, 1'b0, 3'd0);
    s_data_i  = 8'h62;
    s_last_i  = 1'b0;
    m_ready_i = 3'b101;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp_ready", 32'(s_ready_o), 32'd0);
      chk("bp_hold_data", 32'(lane_data(1)), 32'h61);
      chk("bp_hold_valid", 32'(m_valid_o), 32'b010);
      @(posedge clk);
      #1;
    end
    m_ready_i = 3'b111;
    #1;
    chk("bp_release_ready", 32'(s_ready_o), 32'd1);
    @(posedge clk);
    #1;
    chk("bp_b2_data", 32'(lane_data(1)), 32'h62);
    chk("bp_b2_valid", 32'(m_valid_o), 32'b010);
    send_beat(8'h63, 2'd2, 1'b1, 3'd0);
    chk("bp_b3_data", 32'(lane_data(1)), 32'h63);
    chk("bp_b3_last", 32'(m_last_o[1]), 32'd1);
    idle_cycle();
    chk("bp_drain", 32'(m_valid_o), 32'd0);

    // 5: out-of-range destination
    chk("bad_err_before", 32'(err_cnt_o), 32'd0);
    send_beat(8'h71, 2'd3, 1'b0, 3'd2);
`ifdef STREAM_ROUTER_DROP_BAD_DEST_EN
    chk("bad_b1_dropped", 32'(m_valid_o), 32'd0);
    send_beat(8'h72, 2'd0, 1'b1, 3'd2);
    chk("bad_b2_dropped", 32'(m_valid_o), 32'd0);
    chk("bad_err_after", 32'(err_cnt_o), 32'd1);
    send_beat(8'h73, 2'd1, 1'b1, 3'd2);
    chk("bad_next_valid", 32'(m_valid_o), 32'b010);
    chk("bad_next_data", 32'(lane_data(1)), 32'h73);
    chk("bad_err_hold", 32'(err_cnt_o), 32'd1);
`else
    chk("bad_b1_valid", 32'(m_valid_o), 32'b100);
    chk("bad_b1_data", 32'(lane_data(2)), 32'h71);
    send_beat(8'h72, 2'd0, 1'b1, 3'd2);
    chk("bad_b2_valid", 32'(m_valid_o), 32'b100);
    chk("bad_b2_data", 32'(lane_data(2)), 32'h72);
    chk("bad_b2_last", 32'(m_last_o[2]), 32'd1);
    chk("bad_err_after", 32'(err_cnt_o), 32'd0);
`endif
    idle_cycle();

    // 6: random valid/ready, random dest/length, per-lane scoreboard
    pkt_left = 0;
    first    = 0;
    pkt_bad  = 0;
    accepted = 0;
    beats    = 0;
    cycles   = 0;
    pkt_dest = 2'd0;
    while (beats < 10000 && cycles < 60000) begin
      if (!s_valid_i || accepted != 0) begin
        if ($urandom_range(0, 3) != 0) begin
          if (pkt_left == 0) begin
            pkt_left = $urandom_range(1, 4);
            pkt_dest = 2'($urandom_range(0, 3));
            first    = 1;
          end
          s_data_i  = 8'($urandom);
          s_id_i    = 3'($urandom_range(0, 4));
          s_dest_i  = (first != 0) ? pkt_dest : 2'($urandom_range(0, 3));
          s_last_i  = (pkt_left == 1);
          s_valid_i = 1'b1;
        end else begin
          s_valid_i = 1'b0;
        end
      end
      m_ready_i = 3'($urandom_range(0, 7));
      #1;
      accepted = (s_valid_i && s_ready_o) ? 1 : 0;
      if (accepted != 0) begin
`ifdef STREAM_ROUTER_DROP_BAD_DEST_EN
        if (first != 0) pkt_bad = (pkt_dest == 2'd3) ? 1 : 0;
`else
        pkt_bad = 0;
`endif
        if (pkt_bad == 0) exp_q[lane_of(pkt_dest)].push_back({s_last_i, s_id_i, s_data_i});
        pkt_left--;
        first = 0;
        beats++;
      end
      for (int k = 0; k < M; k++) begin
        if (m_valid_o[k] && m_ready_i[k]) begin
          if (exp_q[k].size() == 0) begin
            chk("rand_unexpected_beat", 32'(k), 32'hFF);
          end else begin
            ent = exp_q[k].pop_front();
            chk("rand_beat", 32'({m_last_o[k], lane_id(k), lane_data(k)}), 32'(ent));
          end
        end
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("rand_budget", 32'(beats >= 10000), 32'd1);
    s_valid_i = 1'b0;
    m_ready_i = 3'b111;
    for (int c = 0; c < 3; c++) begin
      #1;
      for (int k = 0; k < M; k++) begin
        if (m_valid_o[k] && m_ready_i[k]) begin
          if (exp_q[k].size() == 0) begin
            chk("drain_unexpected_beat", 32'(k), 32'hFF);
          end else begin
            ent = exp_q[k].pop_front();
            chk("drain_beat", 32'({m_last_o[k], lane_id(k), lane_data(k)}), 32'(ent));
          end
        end
      end
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < M; k++) begin
      chk("rand_leftover", 32'(exp_q[k].size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
